// File: rtl/mig_pkg.sv
// Shared MIG app-interface definitions used by the read and write controllers.
package mig_pkg;

  localparam logic [2:0] MIG_CMD_WR = 3'b000;
  localparam logic [2:0] MIG_CMD_RD = 3'b001;

  localparam int MIG_ADDR_W    = 28;
  localparam int MIG_DATA_W    = 128;
  localparam int MIG_ADDR_INC  = 8;
  localparam int MIG_LEN_W     = 16;
  localparam int MIG_DATA_LEAD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/mig_ctrl_wr.sv
// Burst write controller for the MIG native app port: pops FWFT beats onto the
// write-data channel and issues one write command per beat, data leading by at most DATA_LEAD.
module mig_ctrl_wr
  import mig_pkg::*;
#(
  parameter int ADDR_W    = MIG_ADDR_W,
  parameter int DATA_W    = MIG_DATA_W,
  parameter int LEN_W     = MIG_LEN_W,
  parameter int ADDR_INC  = MIG_ADDR_INC,
  parameter int DATA_LEAD = MIG_DATA_LEAD
) (
  input  logic                ui_clk,
  input  logic                rst_n,
  input  logic                init_calib_complete,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_req_addr,
  input  logic [LEN_W-1:0]    wr_length,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_data_valid,
  output logic                wr_data_ready,
  output logic                wr_busy,
  output logic                wr_done,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_rdy
);

  wr_state_e          state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   data_cnt_q, data_cnt_d;
  logic [LEN_W-1:0]   cmd_cnt_q, cmd_cnt_d;
  logic [ADDR_W-1:0]  addr_cur_q, addr_cur_d;

  logic               start_s;
  logic               start_burst_s;
  logic               cmd_acc_s;
  logic               last_cmd_s;
  logic [LEN_W-1:0]   lead_s;

  assign start_s       = (state_q == IDLE) && wr_req && init_calib_complete;
  assign start_burst_s = start_s && (wr_length != {LEN_W{1'b0}});
  assign lead_s        = data_cnt_q - cmd_cnt_q;
  assign cmd_acc_s     = app_en && app_rdy;
  assign last_cmd_s    = cmd_acc_s && (cmd_cnt_q == (len_q - LEN_W'(1)));

  // State and datapath registers
  always_ff @(posedge ui_clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= {LEN_W{1'b0}};
      data_cnt_q <= {LEN_W{1'b0}};
      cmd_cnt_q  <= {LEN_W{1'b0}};
      addr_cur_q <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      data_cnt_q <= data_cnt_d;
      cmd_cnt_q  <= cmd_cnt_d;
      addr_cur_q <= addr_cur_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = (wr_length == {LEN_W{1'b0}}) ? DONE : WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (last_cmd_s) begin
          state_d = DONE;
        end else begin
          state_d = WRITE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter and address next-state; data and command channels advance independently
  always_comb begin
    len_d      = len_q;
    data_cnt_d = data_cnt_q;
    cmd_cnt_d  = cmd_cnt_q;
    addr_cur_d = addr_cur_q;
    if (start_burst_s) begin
      len_d      = wr_length;
      addr_cur_d = wr_req_addr;
      data_cnt_d = {LEN_W{1'b0}};
      cmd_cnt_d  = {LEN_W{1'b0}};
    end else begin
      if (app_wdf_wren) begin
        data_cnt_d = data_cnt_q + LEN_W'(1);
      end else begin
        data_cnt_d = data_cnt_q;
      end
      if (cmd_acc_s) begin
        cmd_cnt_d  = cmd_cnt_q + LEN_W'(1);
        addr_cur_d = addr_cur_q + ADDR_W'(ADDR_INC);
      end else begin
        cmd_cnt_d  = cmd_cnt_q;
        addr_cur_d = addr_cur_q;
      end
    end
  end

  // Output decode; app_en uses registered state only so it holds while app_rdy is low
  always_comb begin
    wr_data_ready = (state_q == WRITE) && (data_cnt_q < len_q) &&
                    (lead_s < LEN_W'(DATA_LEAD)) && app_wdf_rdy;
    app_wdf_wren  = wr_data_ready && wr_data_valid;
    app_wdf_end   = app_wdf_wren;
    app_en        = (state_q == WRITE) && (cmd_cnt_q < len_q) && (cmd_cnt_q < data_cnt_q);
    wr_busy       = (state_q != IDLE);
    wr_done       = (state_q == DONE);
  end

  assign app_addr     = addr_cur_q;
  assign app_cmd      = MIG_CMD_WR;
  assign app_wdf_data = wr_data;
  assign app_wdf_mask = {(DATA_W/8){1'b0}};

endmodule

// File: tb/tb_mig_ctrl_wr.sv
// Directed bench for mig_ctrl_wr: cycle-exact vector table plus scoreboarded
// backpressure, lead-limit, underflow and reset-mid-burst sequences.
module tb_mig_ctrl_wr;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int LEN_W  = 16;

  logic                ui_clk = 1'b0;
  logic                rst_n;
  logic                init_calib_complete;
  logic                wr_req;
  logic [ADDR_W-1:0]   wr_req_addr;
  logic [LEN_W-1:0]    wr_length;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_data_valid;
  logic                wr_data_ready;
  logic                wr_busy;
  logic                wr_done;
  logic [ADDR_W-1:0]   app_addr;
  logic [2:0]          app_cmd;
  logic                app_en;
  logic                app_rdy;
  logic [DATA_W-1:0]   app_wdf_data;
  logic                app_wdf_wren;
  logic                app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic                app_wdf_rdy;

  always #5 ui_clk = ~ui_clk;

  mig_ctrl_wr dut (
    .ui_clk              (ui_clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .wr_req              (wr_req),
    .wr_req_addr         (wr_req_addr),
    .wr_length           (wr_length),
    .wr_data             (wr_data),
    .wr_data_valid       (wr_data_valid),
    .wr_data_ready       (wr_data_ready),
    .wr_busy             (wr_busy),
    .wr_done             (wr_done),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_rdy         (app_wdf_rdy)
  );

  typedef struct {
    logic              req;
    logic              calib;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              e_ready;
    logic              e_wren;
    logic              e_en;
    logic [ADDR_W-1:0] e_addr;
    logic              e_busy;
    logic              e_done;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic req, input logic calib, input logic [ADDR_W-1:0] addr,
                               input logic [LEN_W-1:0] len, input logic e_ready, input logic e_wren,
                               input logic e_en, input logic [ADDR_W-1:0] e_addr,
                               input logic e_busy, input logic e_done);
    vec_t v;
    v.req = req; v.calib = calib; v.addr = addr; v.len = len;
    v.e_ready = e_ready; v.e_wren = e_wren; v.e_en = e_en;
    v.e_addr = e_addr; v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_en"},    app_en,        1'b0);
    check({tag, "_wren"},  app_wdf_wren,  1'b0);
    check({tag, "_ready"}, wr_data_ready, 1'b0);
    check({tag, "_done"},  wr_done,       1'b0);
    check({tag, "_busy"},  wr_busy,       1'b0);
    check({tag, "_addr"},  app_addr,      28'h0);
  endtask

  // mode 0: all ready; 1: app_rdy low c2..5, wdf_rdy toggling; 2: app_rdy low c1..10; 3: valid low c3..12
  task automatic run_burst(input logic [ADDR_W-1:0] base, input int len, input int mode,
                           output int max_lead);
    int  data_seen = 0;
    int  cmd_seen  = 0;
    int  last_c    = -10;
    bit  finished  = 1'b0;
    logic exp_ready, exp_wren, exp_en;
    logic [ADDR_W-1:0] ea;
    max_lead = 0;
    @(negedge ui_clk);
    wr_req = 1'b1; wr_req_addr = base; wr_length = LEN_W'(len);
    init_calib_complete = 1'b1; wr_data_valid = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    @(negedge ui_clk);
    wr_req = 1'b0;
    for (int c = 0; c < 300 && !finished; c++) begin
      app_rdy       = 1'b1;
      app_wdf_rdy   = 1'b1;
      wr_data_valid = 1'b1;
      case (mode)
        1: begin app_rdy = !(c >= 2 && c <= 5); app_wdf_rdy = (c % 2 == 0); end
        2: app_rdy = !(c >= 1 && c <= 10);
        3: wr_data_valid = !(c >= 3 && c <= 12);
        default: ;
      endcase
      wr_data = {4{32'hD000_0000 + 32'(c)}};
      #1;
      if (wr_done) begin
        check("done_data_cnt", 128'(data_seen), 128'(len));
        check("done_cmd_cnt",  128'(cmd_seen),  128'(len));
        check("done_timing",   128'(c),         128'(last_c + 1));
        check("done_en",       app_en,       1'b0);
        check("done_wren",     app_wdf_wren, 1'b0);
        check("done_busy",     wr_busy,      1'b1);
        finished = 1'b1;
      end else begin
        exp_ready = (data_seen < len) && ((data_seen - cmd_seen) < 4) && app_wdf_rdy;
        exp_wren  = exp_ready && wr_data_valid;
        exp_en    = (cmd_seen < len) && (cmd_seen < data_seen);
        check("burst_busy",  wr_busy,       1'b1);
        check("burst_ready", wr_data_ready, exp_ready);
        check("burst_wren",  app_wdf_wren,  exp_wren);
        check("burst_end",   app_wdf_end,   exp_wren);
        check("burst_en",    app_en,        exp_en);
        if (app_wdf_wren) check("burst_wdata", app_wdf_data, wr_data);
        if (app_en) begin
          ea = base + ADDR_W'(cmd_seen * 8);
          check("burst_addr", app_addr, ea);
        end
        if (app_wdf_wren) data_seen++;
        if (app_en && app_rdy) begin cmd_seen++; last_c = c; end
        if (data_seen - cmd_seen > max_lead) max_lead = data_seen - cmd_seen;
        @(negedge ui_clk);
      end
    end
    if (!finished) check("burst_timeout", 1'b0, 1'b1);
    @(negedge ui_clk);
    #1;
    check("post_burst_busy", wr_busy, 1'b0);
    app_rdy = 1'b1; app_wdf_rdy = 1'b1; wr_data_valid = 1'b1;
  endtask

  initial begin
    int lead;
    rst_n = 1'b0; init_calib_complete = 1'b1; wr_req = 1'b0;
    wr_req_addr = 28'h0; wr_length = 16'h0; wr_data = 128'h0;
    wr_data_valid = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;

    //             req calib addr          len    rdy wren en  e_addr        busy done
    vecs[0]  = mkv(1, 1, 28'h0000100, 16'd4, 0, 0, 0, 28'h0000000, 0, 0);
    vecs[1]  = mkv(0, 1, 28'h0000000, 16'd0, 1, 1, 0, 28'h0000100, 1, 0);
    vecs[2]  = mkv(0, 1, 28'h0000000, 16'd0, 1, 1, 1, 28'h0000100, 1, 0);
    vecs[3]  = mkv(0, 1, 28'h0000000, 16'd0, 1, 1, 1, 28'h0000108, 1, 0);
    vecs[4]  = mkv(0, 1, 28'h0000000, 16'd0, 1, 1, 1, 28'h0000110, 1, 0);
    vecs[5]  = mkv(0, 1, 28'h0000000, 16'd0, 0, 0, 1, 28'h0000118, 1, 0);
    vecs[6]  = mkv(0, 1, 28'h0000000, 16'd0, 0, 0, 0, 28'h0000120, 1, 1);
    vecs[7]  = mkv(0, 1, 28'h0000000, 16'd0, 0, 0, 0, 28'h0000120, 0, 0);
    vecs[8]  = mkv(1, 0, 28'h0000300, 16'd2, 0, 0, 0, 28'h0000120, 0, 0);
    vecs[9]  = mkv(0, 1, 28'h0000000, 16'd0, 0, 0, 0, 28'h0000120, 0, 0);
    vecs[10] = mkv(1, 1, 28'h0000500, 16'd0, 0, 0, 0, 28'h0000120, 0, 0);
    vecs[11] = mkv(0, 1, 28'h0000000, 16'd0, 0, 0, 0, 28'h0000120, 1, 1);
    vecs[12] = mkv(0, 1, 28'h0000000, 16'd0, 0, 0, 0, 28'h0000120, 0, 0);
    vecs[13] = mkv(1, 1, 28'hFFFFFF8, 16'd2, 0, 0, 0, 28'h0000120, 0, 0);
    vecs[14] = mkv(0, 1, 28'h0000000, 16'd0, 1, 1, 0, 28'hFFFFFF8, 1, 0);
    vecs[15] = mkv(1, 1, 28'h0000700, 16'd5, 1, 1, 1, 28'hFFFFFF8, 1, 0);
    vecs[16] = mkv(0, 1, 28'h0000000, 16'd0, 0, 0, 1, 28'h0000000, 1, 0);
    vecs[17] = mkv(0, 1, 28'h0000000, 16'd0, 0, 0, 0, 28'h0000008, 1, 1);
    vecs[18] = mkv(0, 1, 28'h0000000, 16'd0, 0, 0, 0, 28'h0000008, 0, 0);
    vecs[19] = mkv(0, 1, 28'h0000000, 16'd0, 0, 0, 0, 28'h0000008, 0, 0);

    repeat (2) @(negedge ui_clk);
    #1;
    check_idle_outputs("reset");
    check("reset_cmd",  app_cmd,      3'b000);
    check("reset_mask", app_wdf_mask, 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge ui_clk);
      wr_req = vecs[i].req; init_calib_complete = vecs[i].calib;
      wr_req_addr = vecs[i].addr; wr_length = vecs[i].len;
      wr_data = {4{32'hA500_0000 + 32'(i)}};
      #1;
      check($sformatf("vec%0d_ready", i), wr_data_ready, vecs[i].e_ready);
      check($sformatf("vec%0d_wren", i),  app_wdf_wren,  vecs[i].e_wren);
      check($sformatf("vec%0d_end", i),   app_wdf_end,   vecs[i].e_wren);
      check($sformatf("vec%0d_en", i),    app_en,        vecs[i].e_en);
      check($sformatf("vec%0d_addr", i),  app_addr,      vecs[i].e_addr);
      check($sformatf("vec%0d_busy", i),  wr_busy,       vecs[i].e_busy);
      check($sformatf("vec%0d_done", i),  wr_done,       vecs[i].e_done);
      check($sformatf("vec%0d_wdata", i), app_wdf_data,  wr_data);
    end
    wr_req = 1'b0; init_calib_complete = 1'b1;

    run_burst(28'h0002000, 8, 1, lead);
    check("bp_lead_bound", 128'(lead <= 4), 1'b1);
    run_burst(28'h0003000, 8, 2, lead);
    check("lead_max", 128'(lead), 128'(4));
    run_burst(28'h0004000, 8, 3, lead);

    // reset after 3 of 6 beats have been accepted
    @(negedge ui_clk);
    wr_req = 1'b1; wr_req_addr = 28'h0000200; wr_length = 16'd6;
    @(negedge ui_clk);
    wr_req = 1'b0;
    repeat (3) @(negedge ui_clk);
    rst_n = 1'b0;
    @(negedge ui_clk);
    rst_n = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge ui_clk);
    #1;
    check_idle_outputs("midrst_noresume");

    run_burst(28'h0000040, 2, 0, lead);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mig_ctrl_wr.md
Name: mig_ctrl_wr

Overview:
Write-side controller for the MIG 7-series native app interface, the counterpart of the read controller on the same MIG port. It accepts a burst write request (base address and beat count), pulls 128-bit beats from an upstream first-word-fall-through (FWFT) FIFO, and drives the MIG write-data and command channels independently. Data always leads or matches commands, and the data lead is bounded. It sits between the frame/packet buffering logic and the MIG core in the ui_clk domain.

Parameters:
ADDR_W, 28, MIG app address width
DATA_W, 128, app data width (one BL8 beat, 4:1 mode)
LEN_W, 16, beat-count width
ADDR_INC, 8, app_addr increment per command
DATA_LEAD, 4, maximum beats of accepted write data ahead of accepted commands (minimum 1)

Ports:
ui_clk  in  1  MIG user clock; the only clock
rst_n  in  1  reset, synchronous, active-low
init_calib_complete  in  1  MIG calibration done; requests are ignored while low
wr_req  in  1  request pulse, sampled in IDLE only
wr_req_addr  in  ADDR_W  burst base address
wr_length  in  LEN_W  number of beats
wr_data  in  DATA_W  upstream FIFO head data
wr_data_valid  in  1  upstream FIFO not empty
wr_data_ready  out  1  pop strobe to upstream FIFO
wr_busy  out  1  high from request accept until wr_done
wr_done  out  1  one-cycle completion pulse
app_addr  out  ADDR_W  MIG command address
app_cmd  out  3  constant 3'b000 (write)
app_en  out  1  MIG command strobe
app_rdy  in  1  MIG command accept
app_wdf_data  out  DATA_W  write data
app_wdf_wren  out  1  write-data strobe
app_wdf_end  out  1  equal to app_wdf_wren (single beat per burst)
app_wdf_mask  out  DATA_W/8  constant zero
app_wdf_rdy  in  1  MIG write FIFO ready

Behaviour:
- FSM states: IDLE, WRITE, DONE.
- IDLE -> WRITE when wr_req && init_calib_complete && wr_length != 0.
  - On this transition, latch len_q <= wr_length and addr_cur <= wr_req_addr.
  - Clear data_cnt and cmd_cnt.
- IDLE -> DONE when wr_req && init_calib_complete && wr_length == 0. There is no MIG traffic.
- wr_req is ignored outside IDLE, and while calibration is incomplete. Requests are not queued.
- Data channel:
  - wr_data_ready = (state==WRITE) && data_cnt < len_q && (data_cnt - cmd_cnt) < DATA_LEAD && app_wdf_rdy.
  - app_wdf_wren = wr_data_ready && wr_data_valid.
  - app_wdf_data = wr_data, combinational pass-through.
  - data_cnt increments on app_wdf_wren.
- Command channel:
  - app_en = (state==WRITE) && cmd_cnt < len_q && cmd_cnt < data_cnt.
  - app_en is driven only from registers; it never depends on app_rdy.
  - On app_en && app_rdy: cmd_cnt++ and addr_cur += ADDR_INC.
  - app_addr = addr_cur.
  - While app_rdy is low, app_en and app_addr are held stable.
- Same-cycle data and command acceptance is allowed. Both counters update independently in that cycle.
- WRITE -> DONE on the cycle when the final command is accepted (cmd_cnt == len_q-1 && app_en && app_rdy). data_cnt == len_q is guaranteed at that point by the ordering rule.
- DONE -> IDLE unconditionally after one cycle.
- wr_done = (state==DONE). It is registered, so it asserts the cycle after the last command handshake.
- wr_busy = (state != IDLE). It is therefore high during DONE.
- Arithmetic:
  - Counters are LEN_W bits.
  - addr_cur wraps modulo 2^ADDR_W silently.
  - Maximum length is 2^LEN_W - 1.
- Reset (any cycle, including mid-burst):
  - State goes to IDLE; counters and addr_cur clear to 0.
  - All strobes go low: app_en, app_wdf_wren, wr_data_ready, wr_done, wr_busy.
  - app_addr resets to 0.
  - An in-flight burst is abandoned and does not resume.
- Upstream underflow (wr_data_valid low) stalls only the data channel. Commands stop once cmd_cnt == data_cnt.

Decomposition:
- Shared package mig_pkg holds:
  - constants MIG_CMD_WR = 3'b000 and MIG_CMD_RD = 3'b001;
  - ADDR_W, DATA_W, ADDR_INC defaults;
  - the state enum {IDLE, WRITE, DONE}.
- No sub-module is needed. The block is a single FSM with two counters and an address register.

Test Plan:
- Basic burst: wr_req, addr 0x100, len 4, MIG always ready, FIFO always valid -> 4 wren beats on consecutive cycles; app_addr 0x100, 0x108, 0x110, 0x118; wr_done one cycle after the 4th command.
- Backpressure: app_rdy low cycles 2–5 and app_wdf_rdy toggling, len 8 -> app_en and app_addr held stable while app_rdy is low; data lead never exceeds 4; exactly 8 data beats and 8 commands.
- Underflow: wr_data_valid low for 10 cycles mid-burst -> no wren; app_en deasserts once cmd_cnt == data_cnt; the burst resumes and completes with correct addresses.
- Edge cases:
  - len 0 -> wr_done one cycle later, no app_en or wren.
  - wr_req while busy -> ignored.
  - wr_req with init_calib_complete = 0 -> ignored.
- Wrap: addr 0xFFFFFF8, len 2 -> app_addr 0xFFFFFF8, then 0x0000000.
- Reset mid-burst: rst_n low for one cycle after 3 of 6 beats -> all outputs zero next cycle; a subsequent request addr 0x40, len 2 completes normally.
